pwm_ramp_ctrl: RTL
==================

Name: pwm_ramp_ctrl

Overview:
Sequencer that drives one pwm channel's en/period/duty_cycle/polarity inputs. It ramps the duty cycle in fixed steps at frame (PWM period) boundaries for soft-start and soft-stop, and applies run-time retargets glitch-free at frame boundaries. Sits between the register interface (command strobes and config words) and the pwm instance.

Parameters:
COUNTER_WIDTH, 32, width of period, duty, target and step values; must match the driven pwm instance.
HOLD_WIDTH, 16, width of the frames-per-step hold count.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
cmd_start  input  1  one-cycle pulse; begin soft-start from duty 0
cmd_stop  input  1  one-cycle pulse; begin soft-stop to duty 0, then disable
cfg_wr  input  1  one-cycle pulse; latch cfg_* into shadow registers
cfg_period  input  COUNTER_WIDTH  PWM period (frame = period+1 clocks)
cfg_target  input  COUNTER_WIDTH  requested steady duty
cfg_step  input  COUNTER_WIDTH  duty increment or decrement per step; 0 means jump
cfg_hold  input  HOLD_WIDTH  frames per step minus 1
cfg_polarity  input  1  output polarity passed to pwm
pwm_en  output  1  to pwm en
pwm_period  output  COUNTER_WIDTH  to pwm period
pwm_duty  output  COUNTER_WIDTH  to pwm duty_cycle
pwm_polarity  output  1  to pwm polarity
busy  output  1  high in any state except IDLE
at_target  output  1  high in STEADY
done  output  1  one-cycle pulse when a ramp completes (entering STEADY or IDLE)
frame_tick  output  1  high on the last clock of each frame while not IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE; frame counter and hold counter 0; pwm_en=0, pwm_duty=0, pwm_period=0, pwm_polarity=0; busy, at_target, done and frame_tick all 0; shadow registers 0.
- cfg_wr: shadow registers load on the next rising edge in any state.
  - In IDLE, pwm_period and pwm_polarity follow the shadow registers one cycle after cfg_wr.
  - While running, period, polarity, target, step and hold changes take effect only at the next frame_tick.
  - If cfg_wr and a command strobe occur in the same cycle, the command uses the newly written values.
- Effective target: min(shadow target, active period). A duty equal to period is the maximum.
- Frame counter: counts 0..active period and wraps to 0. frame_tick = busy AND (count == active period). With period=0, frame_tick is high every cycle.
- States: IDLE, RAMP, STEADY, STOP.
  - IDLE: frame counter held at 0; pwm_en=0; pwm_duty=0.
    - cmd_start: next cycle enter RAMP with pwm_en=1, pwm_duty=0, counters 0.
    - cmd_stop: ignored.
    - cmd_start and cmd_stop together: stop wins, so the block stays IDLE.
  - RAMP: on each frame_tick the hold counter increments. When the hold counter equals active hold, it clears and one step is applied:
    - Increasing: duty = min(duty + step, target), computed COUNTER_WIDTH+1 wide; duty never wraps.
    - Decreasing: duty = target if (duty - target) <= step, else duty - step.
    - step = 0: duty = target on that step.
    - If the new duty equals target: go to STEADY and pulse done.
  - STEADY: duty held. At each frame_tick the shadow registers are applied; if the effective target differs from duty, go to RAMP with the hold counter at 0.
  - STOP: same stepping as RAMP with target forced to 0. When duty reaches 0 at a step: next cycle pwm_en=0, go to IDLE, pulse done.
  - cmd_stop in RAMP or STEADY: go to STOP next cycle; hold counter cleared; duty unchanged.
  - cmd_start while busy: ignored.
- pwm_duty, pwm_period and pwm_polarity change only on the cycle after a frame_tick, except on the IDLE→RAMP and STOP→IDLE transitions.
- Ramp start with target already 0: at the first applied step, go directly to STEADY (duty 0, pwm_en=1) and pulse done.
- Reset asserted mid-ramp: immediate return to reset values; no done pulse.

Test Plan:
- Soft-start: period=9, target=6, step=2, hold=0; cmd_start → pwm_en rises next cycle; duty 0→2→4→6 at frames 1–3, changing every 10 clocks; done pulse and at_target=1 after 3rd step.
- Hold and saturation: period=99, target=50, step=20, hold=1 → duty 20, 40, 50 every 200 clocks; no overshoot; done once.
- Retarget and clamp: in STEADY at 50, cfg_wr target=200 (period 99) → effective target 99; duty changes only after next frame_tick; ramps 70, 90, 99.
- Soft-stop: from duty 30, step=10, hold=0, cmd_stop → 20, 10, 0 on frame ticks; then pwm_en=0, IDLE, done pulse; busy falls.
- Edge cases:
  - cmd_start and cmd_stop in the same cycle while IDLE → remains IDLE.
  - step=0, target=40 → duty jumps 0→40 in one step.
  - period=0 → frame_tick high every cycle while busy.
- Async reset: assert rst low mid-RAMP between clock edges → all outputs 0 immediately; no done pulse; restart after release works.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer for one pwm channel: soft-start / soft-stop ramps and
// glitch-free retargeting, with every change applied on a frame boundary.
module pwm_ramp_ctrl #(
   parameter int COUNTER_WIDTH = 32,
   parameter int HOLD_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_start,
   input  logic                     cmd_stop,
   input  logic                     cfg_wr,
   input  logic [COUNTER_WIDTH-1:0] cfg_period,
   input  logic [COUNTER_WIDTH-1:0] cfg_target,
   input  logic [COUNTER_WIDTH-1:0] cfg_step,
   input  logic [HOLD_WIDTH-1:0]    cfg_hold,
   input  logic                     cfg_polarity,
   output logic                     pwm_en,
   output logic [COUNTER_WIDTH-1:0] pwm_period,
   output logic [COUNTER_WIDTH-1:0] pwm_duty,
   output logic                     pwm_polarity,
   output logic                     busy,
   output logic                     at_target,
   output logic                     done,
   output logic                     frame_tick
);

   typedef enum logic [1:0] {IDLE, RAMP, STEADY, STOP} state_t;

   state_t                   state, state_nxt;
   logic [COUNTER_WIDTH-1:0] sh_period, sh_target, sh_step;
   logic [HOLD_WIDTH-1:0]    sh_hold;
   logic                     sh_polarity;
   logic [COUNTER_WIDTH-1:0] wr_period;
   logic                     wr_polarity;
   logic [COUNTER_WIDTH-1:0] frame_cnt;
   logic [HOLD_WIDTH-1:0]    hold_cnt, hold_nxt;
   logic                     en_nxt, done_nxt;
   logic [COUNTER_WIDTH-1:0] duty_nxt;
   logic [COUNTER_WIDTH-1:0] eff_target, goal, stepped;
   logic [COUNTER_WIDTH:0]   sum_up;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_period   <= '0;
         sh_target   <= '0;
         sh_step     <= '0;
         sh_hold     <= '0;
         sh_polarity <= 1'b0;
      end else if (cfg_wr) begin
         sh_period   <= cfg_period;
         sh_target   <= cfg_target;
         sh_step     <= cfg_step;
         sh_hold     <= cfg_hold;
         sh_polarity <= cfg_polarity;
      end
   end

   // A write in the same cycle as cmd_start must already be visible to the start.
   assign wr_period   = cfg_wr ? cfg_period   : sh_period;
   assign wr_polarity = cfg_wr ? cfg_polarity : sh_polarity;

   assign busy       = (state != IDLE);
   assign at_target  = (state == STEADY);
   assign frame_tick = busy && (frame_cnt == pwm_period);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt    <= '0;
         pwm_period   <= '0;
         pwm_polarity <= 1'b0;
      end else if (!busy) begin
         frame_cnt    <= '0;
         pwm_period   <= wr_period;
         pwm_polarity <= wr_polarity;
      end else if (frame_tick) begin
         frame_cnt    <= '0;
         pwm_period   <= sh_period;
         pwm_polarity <= sh_polarity;
      end else begin
         frame_cnt    <= frame_cnt + COUNTER_WIDTH'(1);
      end
   end

   // Steps are evaluated only at a frame_tick, where the shadow period becomes active.
   assign eff_target = (sh_target > sh_period) ? sh_period : sh_target;
   assign goal       = (state == STOP) ? '0 : eff_target;
   assign sum_up     = {1'b0, pwm_duty} + {1'b0, sh_step};

   always_comb begin
      stepped = goal;
      if (sh_step != '0) begin
         if (pwm_duty < goal) begin
            if (sum_up < {1'b0, goal}) stepped = sum_up[COUNTER_WIDTH-1:0];
         end else if ((pwm_duty - goal) > sh_step) begin
            stepped = pwm_duty - sh_step;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         pwm_en   <= 1'b0;
         pwm_duty <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         pwm_en   <= en_nxt;
         pwm_duty <= duty_nxt;
         done     <= done_nxt;
      end
   end

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      en_nxt    = pwm_en;
      duty_nxt  = pwm_duty;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_start && !cmd_stop) begin
               state_nxt = RAMP;
               en_nxt    = 1'b1;
               duty_nxt  = '0;
               hold_nxt  = '0;
            end
         end
         RAMP, STOP: begin
            if (state == RAMP && cmd_stop) begin
               state_nxt = STOP;
               hold_nxt  = '0;
            end else if (frame_tick) begin
               if (hold_cnt >= sh_hold) begin
                  hold_nxt = '0;
                  duty_nxt = stepped;
                  if (stepped == goal) begin
                     done_nxt = 1'b1;
                     if (state == STOP) begin
                        state_nxt = IDLE;
                        en_nxt    = 1'b0;
                     end else begin
                        state_nxt = STEADY;
                     end
                  end
               end else begin
                  hold_nxt = hold_cnt + HOLD_WIDTH'(1);
               end
            end
         end
         STEADY: begin
            if (cmd_stop) begin
               state_nxt = STOP;
               hold_nxt  = '0;
            end else if (frame_tick && eff_target != pwm_duty) begin
               state_nxt = RAMP;
               hold_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
